// File: rtl/lsu_mem_master_if.sv
// Bus bundle for lsu_mem_master: core request/response handshake plus the word-wide memory port.
// master = the LSU's view; slave = the core-and-memory side.
interface lsu_mem_master_if #(
    parameter int ADDR_W = 10
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [1:0]        i_req_size;
    logic              i_req_unsigned;
    logic [31:0]       i_req_addr;
    logic [31:0]       i_req_wdata;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [31:0]       o_rsp_rdata;
    logic              o_rsp_err;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;

    modport master (
        input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
        input  i_rsp_ready, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport slave (
        output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
        output i_rsp_ready, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns byte/half/word loads and stores into word accesses (RMW for sub-word stores).
// Optional build macro LSU_RANGE_CHECK_EN: addresses with bits above ADDR_W set are reported as errors.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module lsu_mem_master #(
    parameter int ADDR_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    lsu_mem_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t      state;
    logic        we;
    logic        uns;
    logic [1:0]  size;
    logic [1:0]  off;
    logic [15:0] wdata_lo;
    logic        range_bad;
    logic        req_range_bad;

    generate
        if (`DATA_WIDTH != 32) begin : g_width_chk
            $error("lsu_mem_master requires DATA_WIDTH == 32");
        end
    endgenerate

`ifdef LSU_RANGE_CHECK_EN
    assign req_range_bad = |bus.i_req_addr[31:ADDR_W];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.i_req_addr[31:ADDR_W];
    assign req_range_bad  = 1'b0;
`endif

    // Sizes 10 and 11 are both word accesses.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a != 2'b00));
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] a, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return u ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return u ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] d,
                                          input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] m;
        m = w;
        if (sz == 2'b00)
            m[{a, 3'b000} +: 8] = d[7:0];
        else if (a[1])
            m[31:16] = d;
        else
            m[15:0] = d;
        return m;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            bus.o_req_ready <= 1'b1;
            bus.o_rsp_valid <= 1'b0;
            bus.o_rsp_rdata <= '0;
            bus.o_rsp_err   <= 1'b0;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= '0;
            we              <= 1'b0;
            uns             <= 1'b0;
            size            <= 2'b00;
            off             <= 2'b00;
            wdata_lo        <= '0;
            range_bad       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        we              <= bus.i_req_we;
                        uns             <= bus.i_req_unsigned;
                        size            <= bus.i_req_size;
                        off             <= bus.i_req_addr[1:0];
                        wdata_lo        <= bus.i_req_wdata[15:0];
                        range_bad       <= req_range_bad;
                        bus.o_req_ready <= 1'b0;
                        bus.o_mem_addr  <= {bus.i_req_addr[ADDR_W-1:2], 2'b00};
                        bus.o_mem_wdata <= bus.i_req_wdata;
                        // A full-word store writes during ACCESS, so its enable is decided here.
                        bus.o_mem_we    <= bus.i_req_we & bus.i_req_size[1] & ~req_range_bad
                                           & ~misaligned(bus.i_req_size, bus.i_req_addr[1:0]);
                        state           <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.o_mem_we    <= 1'b0;
                    bus.o_rsp_rdata <= '0;
                    bus.o_rsp_err   <= 1'b0;
                    if (misaligned(size, off) || range_bad) begin
                        bus.o_rsp_err   <= 1'b1;
                        bus.o_rsp_valid <= 1'b1;
                        state           <= RESP;
                    end else if (!we) begin
                        bus.o_rsp_rdata <= load_ext(bus.i_mem_rdata, size, off, uns);
                        bus.o_rsp_valid <= 1'b1;
                        state           <= RESP;
                    end else if (!size[1]) begin
                        bus.o_mem_wdata <= merge(bus.i_mem_rdata, wdata_lo, size, off);
                        bus.o_mem_we    <= 1'b1;
                        state           <= WRITE;
                    end else begin
                        bus.o_rsp_valid <= 1'b1;
                        state           <= RESP;
                    end
                end
                WRITE: begin
                    bus.o_mem_we    <= 1'b0;
                    bus.o_rsp_valid <= 1'b1;
                    state           <= RESP;
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        bus.o_rsp_valid <= 1'b0;
                        bus.o_req_ready <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
